// File: rtl/led_pkg.sv
// Shared types for the LED digit scanner: digit count, digit code and FSM states.
package led_pkg;

    localparam int unsigned NUM_DIG = 8;
    localparam int unsigned IDX_W   = 3;

    // Bit 4 = decimal point, bits 3:0 = hex value.
    typedef logic [4:0] dig_code_t;
    typedef logic [IDX_W-1:0] dig_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } led_state_t;

endpackage

// File: rtl/led_scanner_if.sv
// Register-write, mask and display-drive signals of the LED scanner.
interface led_scanner_if;
    import led_pkg::*;

    logic                   wr_en;
    dig_idx_t               wr_addr;
    dig_code_t              wr_data;
    logic [NUM_DIG-1:0]     dig_mask;
    dig_code_t              dig_ctrl;
    logic                   seg_en;
    logic [NUM_DIG-1:0]     o_an_n;
    logic                   frame_tick;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output dig_mask,
        input  dig_ctrl,
        input  seg_en,
        input  o_an_n,
        input  frame_tick
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  dig_mask,
        output dig_ctrl,
        output seg_en,
        output o_an_n,
        output frame_tick
    );

endinterface

// File: rtl/led_rr_pick.sv
// Circular next-set-bit search: first enabled digit strictly after idx_i, wrapping 7 -> 0.
module led_rr_pick
    import led_pkg::*;
(
    input  logic [NUM_DIG-1:0] mask_i,
    input  dig_idx_t           idx_i,
    output dig_idx_t           next_o,
    output logic               wrap_o,
    output logic               any_o
);

    dig_idx_t cand;
    logic     found;

    always_comb begin
        next_o = idx_i;
        cand   = idx_i;
        found  = 1'b0;
        // Offset NUM_DIG lands back on idx_i, covering the single-digit case.
        for (int unsigned off = 1; off <= NUM_DIG; off++) begin
            cand = idx_i + IDX_W'(off);
            if (!found && mask_i[cand]) begin
                next_o = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_o  = |mask_i;
    assign wrap_o = any_o && (next_o <= idx_i);

endmodule

// File: rtl/led_scanner.sv
// Multiplexed 8-digit LED scanner: blank gap, dwell per enabled digit, frame pulse per pass.
module led_scanner
    import led_pkg::*;
#(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned BLANK = 64
) (
    input  logic          clk,
    input  logic          rst,
    led_scanner_if.slave  bus
);

    localparam int unsigned CntMax = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    led_state_t           state_q, state_d;
    dig_idx_t             idx_q, idx_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    dig_code_t            digit_q [NUM_DIG];

    dig_idx_t             pick_idx;
    dig_idx_t             pick_next;
    logic                 pick_wrap;
    logic                 pick_any;
    logic                 blank_end;
    logic                 dwell_end;

    // In IDLE, searching after index 7 yields the lowest set bit.
    assign pick_idx = (state_q == StIdle) ? dig_idx_t'(NUM_DIG - 1) : idx_q;

    led_rr_pick u_pick (
        .mask_i (bus.dig_mask),
        .idx_i  (pick_idx),
        .next_o (pick_next),
        .wrap_o (pick_wrap),
        .any_o  (pick_any)
    );

    assign blank_end = (cnt_q == CntW'(BLANK - 1));
    // A lit digit whose mask bit drops ends its dwell at the next edge.
    assign dwell_end = (cnt_q == CntW'(DWELL - 1)) || !bus.dig_mask[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIG; i++) begin
                digit_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            digit_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StBlank;
                    idx_d   = pick_next;
                    cnt_d   = '0;
                end
            end
            StBlank: begin
                if (blank_end) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StShow: begin
                if (dwell_end) begin
                    cnt_d = '0;
                    if (!pick_any) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StBlank;
                        idx_d   = pick_next;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.o_an_n     = '1;
        bus.seg_en     = 1'b0;
        bus.frame_tick = 1'b0;
        bus.dig_ctrl   = digit_q[idx_q];
        if (state_q == StShow) begin
            bus.o_an_n     = ~(NUM_DIG'(1) << idx_q);
            bus.seg_en     = 1'b1;
            bus.frame_tick = dwell_end && pick_any && pick_wrap;
        end
    end

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner with DWELL=4, BLANK=2 and immediate-assertion checks.
module tb_led_scanner;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    led_scanner_if u_if ();

    led_scanner #(
        .DWELL (4),
        .BLANK (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, ".an"}, 32'(u_if.o_an_n), 32'hFF);
        check({tag, ".seg"}, 32'(u_if.seg_en), 32'h0);
    endtask

    task automatic check_lit(input string tag, input int d, input logic [4:0] code);
        logic [7:0] an;
        an = 8'hFF ^ (8'h01 << d);
        check({tag, ".an"}, 32'(u_if.o_an_n), 32'(an));
        check({tag, ".seg"}, 32'(u_if.seg_en), 32'h1);
        check({tag, ".ctrl"}, 32'(u_if.dig_ctrl), 32'(code));
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        u_if.wr_en      = 1'b0;
        u_if.wr_addr    = '0;
        u_if.wr_data    = '0;
        u_if.dig_mask   = 8'h00;
        repeat (3) step();
        rst = 1'b0;

        // Reset state and idle with empty mask
        check_dark("rst");
        check("rst.ctrl", 32'(u_if.dig_ctrl), 32'h0);
        check("rst.tick", 32'(u_if.frame_tick), 32'h0);
        for (int c = 0; c < 20; c++) begin
            step();
            check_dark($sformatf("idle%0d", c));
            check($sformatf("idle%0d.tick", c), 32'(u_if.frame_tick), 32'h0);
        end

        // Write visible on dig_ctrl the following cycle
        u_if.wr_en   = 1'b1;
        u_if.wr_addr = 3'd0;
        u_if.wr_data = 5'h15;
        step();
        u_if.wr_en = 1'b0;
        check("wr_vis", 32'(u_if.dig_ctrl), 32'h15);
        for (int i = 0; i < 8; i++) begin
            u_if.wr_en   = 1'b1;
            u_if.wr_addr = 3'(i);
            u_if.wr_data = 5'(i);
            step();
        end
        u_if.wr_en    = 1'b0;

        // Full mask: 2 dark + 4 lit per digit, tick at digit 7 dwell end
        u_if.dig_mask = 8'hFF;
        step();
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 8; d++) begin
                for (int b = 0; b < 2; b++) begin
                    check_dark($sformatf("ff.p%0d.d%0d.b%0d", p, d, b));
                    check($sformatf("ff.p%0d.d%0d.b%0d.ctrl", p, d, b),
                          32'(u_if.dig_ctrl), 32'(d));
                    check($sformatf("ff.p%0d.d%0d.b%0d.tick", p, d, b),
                          32'(u_if.frame_tick), 32'h0);
                    step();
                end
                for (int s = 0; s < 4; s++) begin
                    check_lit($sformatf("ff.p%0d.d%0d.s%0d", p, d, s), d, 5'(d));
                    check($sformatf("ff.p%0d.d%0d.s%0d.tick", p, d, s),
                          32'(u_if.frame_tick), 32'((d == 7) && (s == 3)));
                    step();
                end
            end
        end

        // Mask 0x81: only digits 0 and 7 alternate
        u_if.dig_mask = 8'h81;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) begin
                int d;
                d = (k == 0) ? 0 : 7;
                for (int b = 0; b < 2; b++) begin
                    check_dark($sformatf("m81.p%0d.d%0d.b%0d", p, d, b));
                    step();
                end
                for (int s = 0; s < 4; s++) begin
                    check_lit($sformatf("m81.p%0d.d%0d.s%0d", p, d, s), d, 5'(d));
                    check($sformatf("m81.p%0d.d%0d.s%0d.tick", p, d, s),
                          32'(u_if.frame_tick), 32'((d == 7) && (s == 3)));
                    step();
                end
            end
        end

        // Write to the lit digit mid-SHOW
        u_if.dig_mask = 8'hFF;
        repeat (21) step();
        check_lit("wr3.pre", 3, 5'h03);
        u_if.wr_en   = 1'b1;
        u_if.wr_addr = 3'd3;
        u_if.wr_data = 5'h1A;
        step();
        u_if.wr_en = 1'b0;
        check_lit("wr3.post", 3, 5'h1A);
        step();
        // Write coinciding with dwell end
        u_if.wr_en   = 1'b1;
        u_if.wr_addr = 3'd3;
        u_if.wr_data = 5'h03;
        check("wr3.end.tick", 32'(u_if.frame_tick), 32'h0);
        step();
        u_if.wr_en = 1'b0;
        check_dark("wr3.next");
        check("wr3.next.ctrl", 32'(u_if.dig_ctrl), 32'h04);

        // Clearing the lit digit's mask bit ends the dwell early
        repeat (39) step();
        check_lit("clr2.pre", 2, 5'h02);
        u_if.dig_mask = 8'hFB;
        check("clr2.tick", 32'(u_if.frame_tick), 32'h0);
        step();
        check_dark("clr2.post");
        check("clr2.post.ctrl", 32'(u_if.dig_ctrl), 32'h03);
        repeat (2) step();
        check_lit("clr2.next", 3, 5'h03);

        // Reset mid-SHOW wins over a simultaneous write
        step();
        check_lit("rst.pre", 3, 5'h03);
        rst           = 1'b1;
        u_if.wr_en    = 1'b1;
        u_if.wr_addr  = 3'd0;
        u_if.wr_data  = 5'h1F;
        u_if.dig_mask = 8'hF0;
        step();
        rst        = 1'b0;
        u_if.wr_en = 1'b0;
        check_dark("rstshow");
        check("rstshow.ctrl", 32'(u_if.dig_ctrl), 32'h0);
        check("rstshow.tick", 32'(u_if.frame_tick), 32'h0);
        step();
        check_dark("restart.blank");
        repeat (2) step();
        check_lit("restart.show", 4, 5'h00);

        // Empty mask during SHOW returns to IDLE without a tick
        u_if.dig_mask = 8'h00;
        check("toidle.tick", 32'(u_if.frame_tick), 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_dark($sformatf("toidle%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
